// File: rtl/packer_pkg.sv
// packer_pkg: shared definitions for the beat packer.
//   DATA_WIDTH / NUM_DATA : default lane width and lanes per beat
//   FILL_W                : width of the accumulator fill count (0..2*NUM_DATA-1)
//   state_t               : packer FSM state
//   fill_to_keep()        : fill count -> contiguous output keep mask
package packer_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_DATA   = 32;
  localparam int FILL_W     = $clog2(2 * NUM_DATA);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Lanes below fill are valid; saturates to all ones once fill covers a beat.
  function automatic logic [NUM_DATA-1:0] fill_to_keep(input logic [FILL_W-1:0] fill);
    logic [NUM_DATA-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      mask[i] = (i < int'(fill));
    end
    return mask;
  endfunction

endpackage

// File: rtl/keep_count.sv
// keep_count: combinational popcount of a byte-lane keep mask.
//   keep  : lane valid mask from the compressor
//   count : number of set bits (0..NUM_DATA)
module keep_count
  import packer_pkg::*;
(
  input  logic [NUM_DATA-1:0] keep,
  output logic [FILL_W-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      count = count + FILL_W'(keep[i]);
    end
  end

endmodule

// File: rtl/beat_packer.sv
// beat_packer: repacks variable-length compressed beats into full beats,
// keeping byte order and leaving no gaps between packets.
//   clk, reset                     : clock, synchronous active-low reset
//   s_tdata/s_tkeep/s_tvalid/s_tlast/s_tready : input stream (lanes 0..n-1 used,
//                                    n = popcount(s_tkeep))
//   m_tdata/m_tkeep/m_tvalid/m_tlast/m_tready : packed output stream, keep
//                                    always contiguous from lane 0
//
// state    | meaning
// ST_FILL  | accepting input bytes, emitting each full beat as it forms
// ST_FLUSH | packet end seen; draining remaining bytes, input stalled
module beat_packer #(
  parameter int DATA_WIDTH = packer_pkg::DATA_WIDTH,
  parameter int NUM_DATA   = packer_pkg::NUM_DATA
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] s_tdata,
  input  logic [NUM_DATA-1:0]            s_tkeep,
  input  logic                           s_tvalid,
  input  logic                           s_tlast,
  output logic                           s_tready,
  output logic [DATA_WIDTH*NUM_DATA-1:0] m_tdata,
  output logic [NUM_DATA-1:0]            m_tkeep,
  output logic                           m_tvalid,
  output logic                           m_tlast,
  input  logic                           m_tready
);

  localparam int FILL_BITS = $clog2(2 * NUM_DATA);
  localparam logic [FILL_BITS-1:0] FILL_BEAT = FILL_BITS'(NUM_DATA);

  packer_pkg::state_t                      state;
  logic [FILL_BITS-1:0]                    fill;
  logic [2*NUM_DATA-1:0][DATA_WIDTH-1:0]   acc;

  logic [FILL_BITS-1:0]                    n_bytes;
  logic                                    accept;
  logic                                    pop;
  logic [FILL_BITS-1:0]                    fill_after_pop;
  logic [FILL_BITS-1:0]                    fill_nxt;
  logic [FILL_BITS-1:0]                    lane_idx;
  logic [2*NUM_DATA-1:0][DATA_WIDTH-1:0]   acc_nxt;

  keep_count u_keep_count (
    .keep  (s_tkeep),
    .count (n_bytes)
  );

  // Only m_tready reaches s_tready combinationally; everything else is registered state.
  assign s_tready = (state == packer_pkg::ST_FILL) && ((fill < FILL_BEAT) || m_tready);
  assign m_tvalid = (fill >= FILL_BEAT) || (state == packer_pkg::ST_FLUSH);
  assign m_tlast  = (state == packer_pkg::ST_FLUSH) && (fill <= FILL_BEAT);
  assign m_tkeep  = packer_pkg::fill_to_keep(fill);
  assign m_tdata  = acc[NUM_DATA-1:0];

  assign accept = s_tvalid && s_tready;
  assign pop    = m_tvalid && m_tready;

  always_comb begin
    acc_nxt        = acc;
    fill_after_pop = fill;
    lane_idx       = '0;
    if (pop) begin
      acc_nxt                 = '0;
      acc_nxt[NUM_DATA-1:0]   = acc[2*NUM_DATA-1:NUM_DATA];
      if (m_tlast || (fill < FILL_BEAT)) begin
        fill_after_pop = '0;
      end else begin
        fill_after_pop = fill - FILL_BEAT;
      end
    end
    fill_nxt = fill_after_pop;
    if (accept) begin
      // Accepting implies fill_after_pop < NUM_DATA, so the write never wraps.
      for (int j = 0; j < NUM_DATA; j++) begin
        if (FILL_BITS'(j) < n_bytes) begin
          lane_idx          = fill_after_pop + FILL_BITS'(j);
          acc_nxt[lane_idx] = s_tdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      fill_nxt = fill_after_pop + n_bytes;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= packer_pkg::ST_FILL;
      fill  <= '0;
      acc   <= '0;
    end else begin
      acc  <= acc_nxt;
      fill <= fill_nxt;
      case (state)
        packer_pkg::ST_FILL:  if (accept && s_tlast) state <= packer_pkg::ST_FLUSH;
        packer_pkg::ST_FLUSH: if (pop && m_tlast)    state <= packer_pkg::ST_FILL;
        default:              state <= packer_pkg::ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_packer.sv
// tb_beat_packer: scoreboard bench for beat_packer. A byte-level model builds
// expected output beats as input beats are accepted; a negedge monitor pops and
// compares them whenever an output beat is handed over.
module tb_beat_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;

  beat_packer u_dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pend[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic       rnd_done;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic emit(input int k, input logic last);
    exp_t e;
    e.data = '0;
    e.keep = '0;
    for (int i = 0; i < k; i++) begin
      e.data[i*8 +: 8] = pend.pop_front();
      e.keep[i]        = 1'b1;
    end
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic model_accept(input logic [255:0] d, input logic [31:0] k, input logic l);
    int n;
    n = $countones(k);
    for (int i = 0; i < n; i++) pend.push_back(d[i*8 +: 8]);
    if (!l) begin
      while (pend.size() >= 32) emit(32, 1'b0);
    end else begin
      while (pend.size() > 32) emit(32, 1'b0);
      emit(pend.size(), 1'b1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    int t;
    t = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        model_accept(d, k, l);
        break;
      end
      t++;
      if (t > 1000) begin
        chk("accept_timeout", 256'(t), 256'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain", 256'(sb.size()), 256'(0));
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rep_byte(input logic [7:0] b);
    return {32{b}};
  endfunction

  always @(negedge clk) begin
    if (reset && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 256'(sb.size()), 256'(1));
      end else begin
        exp_t         e;
        logic [255:0] mask;
        e = sb.pop_front();
        for (int i = 0; i < 32; i++) mask[i*8 +: 8] = {8{e.keep[i]}};
        chk("beat_data", m_tdata & mask, e.data);
        chk("beat_keep", 256'(m_tkeep), 256'(e.keep));
        chk("beat_last", 256'(m_tlast), 256'(e.last));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    rnd_done = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", 256'(m_tvalid), 256'(0));
    chk("rst_mkeep",  256'(m_tkeep),  256'(0));
    chk("rst_mlast",  256'(m_tlast),  256'(0));
    chk("rst_sready", 256'(s_tready), 256'(1));
    chk("rst_mdata",  m_tdata,        256'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Two half beats merge into one full beat.
    m_tready = 1'b1;
    send_beat(rep_byte(8'hAA), 32'h0000_FFFF, 1'b0);
    send_beat(rep_byte(8'hBB), 32'h0000_FFFF, 1'b0);
    wait_drain();

    // 20 + 20 byte packet; keep bits scattered but lanes 0..19 are taken.
    m_tready = 1'b0;
    send_beat(rnd256(), 32'hFFFF_F000, 1'b0);
    send_beat(rnd256(), 32'h000F_FFFF, 1'b1);
    @(negedge clk);
    chk("flush_sready", 256'(s_tready), 256'(0));
    chk("flush_mvalid", 256'(m_tvalid), 256'(1));
    chk("flush_keep0",  256'(m_tkeep),  256'(32'hFFFF_FFFF));
    chk("flush_last0",  256'(m_tlast),  256'(0));
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("flush_keep1", 256'(m_tkeep), 256'(32'h0000_00FF));
    chk("flush_last1", 256'(m_tlast), 256'(1));
    chk("flush_sready1", 256'(s_tready), 256'(0));
    wait_drain();

    // Back-pressure on a stream of full beats.
    m_tready = 1'b0;
    fork
      begin
        send_beat(rep_byte(8'h11), 32'hFFFF_FFFF, 1'b0);
        send_beat(rep_byte(8'h22), 32'hFFFF_FFFF, 1'b0);
        send_beat(rep_byte(8'h33), 32'hFFFF_FFFF, 1'b1);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        chk("bp_sready", 256'(s_tready), 256'(0));
        chk("bp_mvalid", 256'(m_tvalid), 256'(1));
        chk("bp_data0",  m_tdata,        rep_byte(8'h11));
        repeat (2) @(negedge clk);
        chk("bp_data_hold", m_tdata,        rep_byte(8'h11));
        chk("bp_keep_hold", 256'(m_tkeep),  256'(32'hFFFF_FFFF));
        chk("bp_last_hold", 256'(m_tlast),  256'(0));
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        @(negedge clk);
        chk("bp_pop_accept", 256'({s_tready, m_tvalid}), 256'(2'b11));
      end
    join
    wait_drain();

    // Zero-byte packet.
    m_tready = 1'b0;
    send_beat(rnd256(), 32'h0, 1'b1);
    @(negedge clk);
    chk("empty_mvalid", 256'(m_tvalid), 256'(1));
    chk("empty_keep",   256'(m_tkeep),  256'(0));
    chk("empty_last",   256'(m_tlast),  256'(1));
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    wait_drain();

    // Reset in FLUSH with 8 bytes buffered.
    m_tready = 1'b0;
    send_beat(rep_byte(8'h5A), 32'h0000_00FF, 1'b1);
    @(negedge clk);
    chk("pre_rst_keep", 256'(m_tkeep), 256'(32'h0000_00FF));
    chk("pre_rst_last", 256'(m_tlast), 256'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    pend.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_mvalid", 256'(m_tvalid), 256'(0));
    chk("post_rst_sready", 256'(s_tready), 256'(1));
    chk("post_rst_keep",   256'(m_tkeep),  256'(0));
    chk("post_rst_data",   m_tdata,        256'(0));
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_beat(rep_byte(8'hCC), 32'h0000_001F, 1'b1);
    @(negedge clk);
    chk("post_rst_lane0", 256'(m_tdata[39:0]), 256'(40'hCC_CCCC_CCCC));
    chk("post_rst_keep2", 256'(m_tkeep),       256'(32'h0000_001F));
    wait_drain();

    // Random packets with random downstream back-pressure.
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          int nb;
          nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) begin
            logic [31:0] k;
            case ($urandom_range(0, 3))
              0:       k = 32'hFFFF_FFFF;
              1:       k = 32'h0;
              default: k = $urandom;
            endcase
            send_beat(rnd256(), k, (b == nb - 1));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    m_tready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/beat_packer.md
BEAT_PACKER -- requirements
Module: beat_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per byte lane.
REQ-002 Parameter NUM_DATA, default 32, byte lanes per beat; beat width = DATA_WIDTH*NUM_DATA (256).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 s_tdata  input  256  compressor output beat; lane 0 = bits [7:0] = first byte in stream order.
REQ-006 s_tkeep  input  32  valid-lane mask from compressor.
REQ-007 s_tvalid  input  1  input beat valid.
REQ-008 s_tlast  input  1  last beat of packet.
REQ-009 s_tready  output  1  packer can accept the input beat.
REQ-010 m_tdata  output  256  packed output beat.
REQ-011 m_tkeep  output  32  valid-lane mask of output beat; always contiguous from lane 0.
REQ-012 m_tvalid  output  1  output beat valid.
REQ-013 m_tlast  output  1  final beat of packed packet.
REQ-014 m_tready  input  1  downstream accepts output beat.

Function
REQ-015 Block SHALL repack variable-length compressed beats into full 32-byte beats, preserving byte order, with no gaps between packets' bytes.
REQ-016 Input byte count n SHALL equal popcount(s_tkeep) (0..32); the packer SHALL take lanes 0..n-1 of s_tdata irrespective of which tkeep bits are set.
REQ-017 State SHALL be a 64-byte accumulator acc, a 6-bit fill count (0..63) and a 2-state FSM {FILL, FLUSH}.
REQ-018 Input handshake: beat accepted when s_tvalid && s_tready; output handshake: beat popped when m_tvalid && m_tready.
REQ-019 s_tready SHALL be 1 only in FILL and when (fill < 32 || m_tready); m_tready -> s_tready is the only combinational path.
REQ-020 m_tvalid SHALL be (fill >= 32) || (state == FLUSH).
REQ-021 m_tdata SHALL be acc lanes 0..31; m_tkeep SHALL be all ones when fill >= 32, else (1<<fill)-1.
REQ-022 m_tlast SHALL be (state == FLUSH && fill <= 32).
REQ-023 On pop, acc SHALL shift down 32 lanes and fill SHALL decrease by min(fill, 32).
REQ-024 On accept, the n bytes SHALL be written at lane offset equal to fill after any same-cycle pop, and fill SHALL increase by n; simultaneous pop and accept SHALL both take effect in the same cycle.
REQ-025 Accepted s_tlast SHALL move FSM FILL -> FLUSH; pop with m_tlast = 1 SHALL set fill = 0 and move FLUSH -> FILL.
REQ-026 Packet totalling zero bytes SHALL yield exactly one output beat, m_tkeep = 0, m_tlast = 1.
REQ-027 Latency: a byte accepted at edge t SHALL be visible on m_tdata from edge t no earlier than the following cycle; no s_tdata -> m_tdata combinational path.
REQ-028 While m_tvalid = 1 and m_tready = 0, m_tdata/m_tkeep/m_tlast SHALL hold stable.
REQ-029 Lanes of m_tdata outside m_tkeep SHALL be don't-care, but SHALL be 0 after reset.

Reset
REQ-030 On reset = 0 at a rising edge: fill = 0, acc = 0, FSM = FILL, so m_tvalid = 0, m_tlast = 0, m_tkeep = 0, s_tready = 1.
REQ-031 Reset asserted mid-packet or mid-FLUSH SHALL discard all buffered bytes; no partial beat emitted afterwards.

Structure
REQ-032 Shared package packer_pkg SHALL hold DATA_WIDTH, NUM_DATA, the FSM state typedef and the fill-to-keep-mask function.
REQ-033 Sub-module keep_count (32-bit mask -> 6-bit popcount, combinational) SHALL compute n.

Verification
REQ-034 Reset: hold reset = 0 two cycles -> m_tvalid = 0, m_tkeep = 0, s_tready = 1.
REQ-035 Two beats tkeep = 0x0000FFFF, data lanes 0xAA then 0xBB, no tlast -> one beat, tkeep = 0xFFFFFFFF, lanes 0-15 = 0xAA, 16-31 = 0xBB, m_tlast = 0.
REQ-036 Beat of 20 bytes then tlast beat of 20 bytes -> full beat (m_tlast = 0) then beat m_tkeep = 0x000000FF, m_tlast = 1; s_tready = 0 during FLUSH.
REQ-037 m_tready = 0, stream of full beats -> first beat accepted, s_tready = 0 next cycle, outputs stable; on m_tready = 1, pop and accept occur in the same cycle.
REQ-038 tlast beat with s_tkeep = 0 while fill = 0 -> single beat m_tkeep = 0, m_tlast = 1.
REQ-039 Reset pulsed while in FLUSH with fill = 8 -> next cycle m_tvalid = 0, s_tready = 1, and the next packet's bytes start at lane 0.
